// File: rtl/serial_receiver_pkg.sv
// Shared constants, state encoding and config helper for the serial receiver.
package serial_receiver_pkg;

  localparam int unsigned SERIAL_DATA_WIDTH = 8;
  localparam int unsigned SERIAL_FIFO_DEPTH = 4;

  typedef enum logic {
    SERIAL_RX_IDLE    = 1'b0,
    SERIAL_RX_RECEIVE = 1'b1
  } rx_state_e;

  function automatic bit is_pow2_ge2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous show-ahead FIFO holding received bytes; push/pop may coincide when full.
module serial_rx_fifo
  import serial_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SERIAL_DATA_WIDTH,
  parameter int unsigned DEPTH      = SERIAL_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  wr_en_c;
  logic                  rd_en_c;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en_c = pop && !empty;
  assign wr_en_c = push && (!full || rd_en_c);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// LSB-first serial deserialiser with valid/ready output stage.
// Define SERIAL_RX_FIFO_EN to buffer bytes in serial_rx_fifo instead of a single holding register.
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SERIAL_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = SERIAL_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  transmission_clock,
  input  logic                  transmission,
  input  logic                  in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int unsigned      CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Configurations outside the supported range elaborate this empty marker.
  if (!is_pow2_ge2(FIFO_DEPTH) || (DATA_WIDTH < 2)) begin : g_unsupported_config
  end

  rx_state_e             state;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] shift;
  logic                  sample_c;
  logic                  push_c;
  logic [DATA_WIDTH-1:0] push_data_c;

  assign sample_c = transmission && transmission_clock;
  assign busy     = (state == SERIAL_RX_RECEIVE);

  // The last bit bypasses the shift register so the byte is pushed on its strobe edge.
  always_comb begin
    push_c      = 1'b0;
    push_data_c = shift;
    if ((state == SERIAL_RX_RECEIVE) && sample_c && (count == LAST_BIT)) begin
      push_c             = 1'b1;
      push_data_c[count] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SERIAL_RX_IDLE;
      count       <= '0;
      shift       <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        SERIAL_RX_IDLE: begin
          if (transmission) begin
            state <= SERIAL_RX_RECEIVE;
            if (transmission_clock) begin
              shift[0] <= in_data;
              count    <= CNT_W'(1);
            end
          end
        end
        SERIAL_RX_RECEIVE: begin
          if (sample_c) begin
            shift[count] <= in_data;
            if (count == LAST_BIT) begin
              count <= '0;
              state <= SERIAL_RX_IDLE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end else if (!transmission) begin
            frame_error <= (count != '0);
            count       <= '0;
            shift       <= '0;
            state       <= SERIAL_RX_IDLE;
          end
        end
        default: state <= SERIAL_RX_IDLE;
      endcase
    end
  end

`ifdef SERIAL_RX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;
  logic pop_c;

  assign pop_c     = !fifo_empty && out_ready;
  assign out_valid = !fifo_empty;

  serial_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (push_data_c),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push_c && fifo_full && !pop_c;
    end
  end
`else
  // Single holding register: a push into an unconsumed byte is dropped, push wins over pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (push_c) begin
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_data  <= push_data_c;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Directed plus randomized bench for serial_receiver against a queue-based byte-stream model.
module tb_serial_receiver;

`ifdef SERIAL_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       transmission_clock;
  logic       transmission;
  logic       in_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_error;
  logic       overrun;

  always #5 clk = ~clk;

  serial_receiver #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .transmission_clock (transmission_clock),
    .transmission       (transmission),
    .in_data            (in_data),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .busy               (busy),
    .frame_error        (frame_error),
    .overrun            (overrun)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned got[$];
  byte unsigned exp_pop[$];
  byte unsigned store[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  bit ready_mode = 1'b1;

  // Observed traffic: accepted bytes and error pulses.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a completed byte is consumed directly, stored, or dropped as an overrun.
  function automatic void model_frame(input byte unsigned b);
    if (ready_mode) exp_pop.push_back(b);
    else if (store.size() < CAP) store.push_back(b);
    else exp_ov++;
  endfunction

  task automatic drain();
    out_ready  = 1'b1;
    ready_mode = 1'b1;
    foreach (store[i]) exp_pop.push_back(store[i]);
    store.delete();
    repeat (CAP + 3) tick();
  endtask

  task automatic send_bits(input byte unsigned b, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      repeat (gap - 1) begin
        tick();
        transmission       = 1'b1;
        transmission_clock = 1'b0;
      end
      tick();
      transmission       = 1'b1;
      transmission_clock = 1'b1;
      in_data            = b[i];
      if (i == 1) chk("busy_mid_frame", busy, 1);
    end
  endtask

  task automatic send_frame(input byte unsigned b, input int gap, input bit keep);
    send_bits(b, DW, gap);
    model_frame(b);
    if (!keep) begin
      tick();
      transmission_clock = 1'b0;
      transmission       = 1'b0;
      chk("busy_after_frame", busy, 0);
      chk("valid_latency", out_valid, 1);
      chk("head_data", out_data, ready_mode ? b : store[0]);
    end
  endtask

  task automatic truncate();
    tick();
    transmission_clock = 1'b0;
    transmission       = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    repeat (4) tick();
    chk($sformatf("%s_count", tag), got.size(), exp_pop.size());
    for (int i = 0; i < got.size() && i < exp_pop.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_pop[i]);
    chk($sformatf("%s_frame_errors", tag), fe_cnt, exp_fe);
    chk($sformatf("%s_overruns", tag), ov_cnt, exp_ov);
    got.delete();
    exp_pop.delete();
  endtask

  initial begin
    byte unsigned b;
    int gap;
    bit keep;

    rst = 1'b0;
    transmission_clock = 1'b0;
    transmission = 1'b0;
    in_data = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b1;
    tick();

    send_frame(8'hA5, 4, 1'b0);
    check_stream("single");

    send_frame(8'h3C, 4, 1'b1);
    send_frame(8'hC3, 4, 1'b0);
    check_stream("back_to_back");

    send_frame(8'h96, 1, 1'b1);
    send_frame(8'h69, 1, 1'b0);
    check_stream("strobe_every_clk");

    send_bits(8'hFF, 3, 4);
    truncate();
    exp_fe++;
    repeat (3) tick();
    chk("truncated_no_valid", out_valid, 0);
    send_frame(8'h5A, 4, 1'b0);
    check_stream("truncated");

    tick();
    transmission = 1'b1;
    repeat (3) tick();
    transmission = 1'b0;
    check_stream("empty_frame");

    out_ready  = 1'b0;
    ready_mode = 1'b0;
    send_frame(8'h11, 4, 1'b0);
    send_frame(8'h22, 4, 1'b0);
    repeat (3) tick();
    chk("held_data", out_data, 8'h11);
    chk("held_valid", out_valid, 1);
    drain();
    check_stream("hold_overrun");

    out_ready  = 1'b0;
    ready_mode = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 3, 1'b0);
    drain();
    check_stream("fill_store");

    send_bits(8'hFF, 5, 4);
    tick();
    transmission_clock = 1'b0;
    chk("busy_before_reset", busy, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    store.delete();
    tick();
    transmission = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send_frame(8'h81, 4, 1'b0);
    check_stream("after_reset");

    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom);
      gap  = int'($urandom_range(1, 5));
      keep = (k < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_frame(b, gap, keep);
    end
    check_stream("random_frames");

    for (int k = 0; k < 3; k++) begin
      send_bits(8'($urandom), int'($urandom_range(1, 7)), 3);
      truncate();
      exp_fe++;
      send_frame(8'($urandom), int'($urandom_range(2, 4)), 1'b0);
    end
    check_stream("random_truncation");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
